// File: rtl/modem_pkg.sv
// Purpose : shared types, constants and frame packing for the TX frame scheduler.
// Contents: scheduler state enum, sync patterns, full-scale sample value,
//           frame width and the sample/end frame builders.
package modem_pkg;

  localparam int unsigned FRAME_W  = 32;
  localparam int unsigned SAMPLE_W = 13;

  localparam logic [1:0]          SYNC_I     = 2'b10;
  localparam logic [1:0]          SYNC_Q     = 2'b01;
  localparam logic [SAMPLE_W-1:0] FULL_SCALE = 13'h0FFF;

  localparam logic [FRAME_W-1:0]  IDLE_FRAME = '0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREPARE = 2'd1,
    ST_SEND    = 2'd2,
    ST_END     = 2'd3
  } state_e;

  // Sample frame: I half carries a trailing 1, Q half a trailing 0.
  function automatic logic [FRAME_W-1:0] pack_sample(input logic [SAMPLE_W-1:0] s_i,
                                                     input logic [SAMPLE_W-1:0] s_q);
    return {SYNC_I, s_i, 1'b1, SYNC_Q, s_q, 1'b0};
  endfunction

  // End frame: both sync patterns with all-zero payload.
  function automatic logic [FRAME_W-1:0] end_frame();
    return {SYNC_I, 14'b0, SYNC_Q, 14'b0};
  endfunction

endpackage

// File: rtl/tx_frame_scheduler.sv
// Purpose : schedules sample/idle/end frames toward the serializer, pacing
//           sample requests to the signal generator per message.
// Ports   : clk, reset_n (sync, active-low)
//           i_transmit (message request level), i_slot (frame boundary strobe),
//           i_pace (idle frames between samples), i_cw (force full scale),
//           i_sample_i/q + i_sample_valid (generator sample), i_msg_done
//           o_gen_enable (sample request pulse), o_tx_data (frame word),
//           o_busy, o_msg_done (end-of-message pulse), o_underrun (sticky),
//           o_frame_cnt (sample frames sent this message)
module tx_frame_scheduler
  import modem_pkg::*;
#(
  parameter int unsigned PACE_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_transmit,
  input  logic                i_slot,
  input  logic [PACE_W-1:0]   i_pace,
  input  logic                i_cw,
  input  logic [SAMPLE_W-1:0] i_sample_i,
  input  logic [SAMPLE_W-1:0] i_sample_q,
  input  logic                i_sample_valid,
  input  logic                i_msg_done,
  output logic                o_gen_enable,
  output logic [FRAME_W-1:0]  o_tx_data,
  output logic                o_busy,
  output logic                o_msg_done,
  output logic                o_underrun,
  output logic [CNT_W-1:0]    o_frame_cnt
);

  state_e               state_q, state_d;
  logic                 trans_q;
  logic                 pending_q, pending_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 entered_q, entered_d;
  logic                 gen_q, gen_d;
  logic                 msg_done_q, msg_done_d;
  logic                 busy_q, busy_d;
  logic                 underrun_q, underrun_d;
  logic [PACE_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [SAMPLE_W-1:0]  hold_i_q, hold_i_d;
  logic [SAMPLE_W-1:0]  hold_q_q, hold_q_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;

  logic trans_rise_c;
  logic trans_fall_c;
  logic sample_rdy_c;

  assign trans_rise_c = i_transmit & ~trans_q;
  assign trans_fall_c = ~i_transmit & trans_q;
  // A sample arriving in the slot clock itself still counts as ready.
  assign sample_rdy_c = ready_q | i_sample_valid;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      trans_q     <= 1'b0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      entered_q   <= 1'b0;
      gen_q       <= 1'b0;
      msg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      slot_cnt_q  <= '0;
      frame_cnt_q <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      tx_q        <= '0;
    end else begin
      state_q     <= state_d;
      trans_q     <= i_transmit;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      entered_q   <= entered_d;
      gen_q       <= gen_d;
      msg_done_q  <= msg_done_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      slot_cnt_q  <= slot_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      tx_q        <= tx_d;
    end
  end

  // Next-state, flag and frame selection; state and frame move only on i_slot.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ready_d     = ready_q;
    done_d      = done_q;
    abort_d     = abort_q;
    entered_d   = 1'b0;
    gen_d       = entered_q;
    msg_done_d  = 1'b0;
    underrun_d  = underrun_q;
    slot_cnt_d  = slot_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hold_i_d    = hold_i_q;
    hold_q_d    = hold_q_q;
    tx_d        = tx_q;

    if (trans_rise_c) pending_d = 1'b1;
    if (i_msg_done)   done_d    = 1'b1;

    if (i_sample_valid) begin
      hold_i_d = i_cw ? FULL_SCALE : i_sample_i;
      hold_q_d = i_cw ? FULL_SCALE : i_sample_q;
      ready_d  = 1'b1;
    end

    if (trans_fall_c && (state_q == ST_PREPARE)) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (i_slot) begin
          tx_d = IDLE_FRAME;
          if (pending_q) begin
            state_d     = ST_PREPARE;
            entered_d   = 1'b1;
            pending_d   = 1'b0;
            slot_cnt_d  = '0;
            frame_cnt_d = '0;
            underrun_d  = 1'b0;
          end
        end
      end
      ST_PREPARE: begin
        if (i_slot) begin
          if (abort_q || trans_fall_c) begin
            tx_d    = end_frame();
            abort_d = 1'b0;
            state_d = ST_END;
          end else if (slot_cnt_q < i_pace) begin
            tx_d       = IDLE_FRAME;
            slot_cnt_d = slot_cnt_q + PACE_W'(1);
          end else if (sample_rdy_c) begin
            tx_d        = pack_sample(hold_i_d, hold_q_d);
            ready_d     = 1'b0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = ST_SEND;
          end else begin
            // Sample late: hold the slot count so it goes out at the next slot.
            tx_d       = IDLE_FRAME;
            underrun_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (i_slot) begin
          if (done_q || i_msg_done || !i_transmit) begin
            tx_d    = end_frame();
            state_d = ST_END;
          end else begin
            tx_d       = IDLE_FRAME;
            slot_cnt_d = '0;
            entered_d  = 1'b1;
            state_d    = ST_PREPARE;
          end
        end
      end
      ST_END: begin
        if (i_slot) begin
          tx_d       = IDLE_FRAME;
          msg_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign o_gen_enable = gen_q;
  assign o_tx_data    = tx_q;
  assign o_busy       = busy_q;
  assign o_msg_done   = msg_done_q;
  assign o_underrun   = underrun_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Purpose : directed bench for tx_frame_scheduler with hand-computed frame words.
module tb_tx_frame_scheduler;

  logic        clk;
  logic        reset_n;
  logic        i_transmit;
  logic        i_slot;
  logic [3:0]  i_pace;
  logic        i_cw;
  logic [12:0] i_sample_i;
  logic [12:0] i_sample_q;
  logic        i_sample_valid;
  logic        i_msg_done;
  logic        o_gen_enable;
  logic [31:0] o_tx_data;
  logic        o_busy;
  logic        o_msg_done;
  logic        o_underrun;
  logic [15:0] o_frame_cnt;

  int vectors;
  int miscompares;

  localparam logic [31:0] END_W = 32'h8000_4000;

  tx_frame_scheduler #(.PACE_W(4), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_transmit     (i_transmit),
    .i_slot         (i_slot),
    .i_pace         (i_pace),
    .i_cw           (i_cw),
    .i_sample_i     (i_sample_i),
    .i_sample_q     (i_sample_q),
    .i_sample_valid (i_sample_valid),
    .i_msg_done     (i_msg_done),
    .o_gen_enable   (o_gen_enable),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_msg_done     (o_msg_done),
    .o_underrun     (o_underrun),
    .o_frame_cnt    (o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-clock frame boundary strobe.
  task automatic slot();
    i_slot = 1'b1;
    tick();
    i_slot = 1'b0;
  endtask

  // Called right after an entry into PREPARE: checks the request pulse,
  // supplies one sample, then expects nidle idle frames and the sample frame.
  task automatic sample_round(input logic [12:0] si, input logic [12:0] sq,
                              input int nidle, input logic [31:0] exp_w,
                              input logic [15:0] exp_cnt);
    tick();
    chk("gen_pulse", 32'(o_gen_enable), 32'd1);
    tick();
    chk("gen_single", 32'(o_gen_enable), 32'd0);
    i_sample_i     = si;
    i_sample_q     = sq;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    for (int k = 0; k < nidle; k++) begin
      slot();
      chk("pace_idle", o_tx_data, 32'h0);
    end
    slot();
    chk("sample_frame", o_tx_data, exp_w);
    chk("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    i_transmit     = 1'b0;
    i_slot         = 1'b0;
    i_pace         = 4'd3;
    i_cw           = 1'b0;
    i_sample_i     = '0;
    i_sample_q     = '0;
    i_sample_valid = 1'b0;
    i_msg_done     = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_tx", o_tx_data, 32'h0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_gen", 32'(o_gen_enable), 32'd0);
    chk("rst_cnt", 32'(o_frame_cnt), 32'd0);
    chk("rst_underrun", 32'(o_underrun), 32'd0);
    chk("rst_msg_done", 32'(o_msg_done), 32'd0);

    // Pace 3, three samples then message done.
    i_transmit = 1'b1;
    tick();
    slot();
    chk("start_idle", o_tx_data, 32'h0);
    chk("start_busy", 32'(o_busy), 32'd1);
    sample_round(13'h0123, 13'h1ABC, 3, 32'h8247_7578, 16'd1);
    slot();
    chk("send_idle1", o_tx_data, 32'h0);
    sample_round(13'h0000, 13'h0000, 3, 32'h8001_4000, 16'd2);
    slot();
    chk("send_idle2", o_tx_data, 32'h0);
    sample_round(13'h1FFF, 13'h0001, 3, 32'hBFFF_4002, 16'd3);
    i_msg_done = 1'b1;
    tick();
    i_msg_done = 1'b0;
    slot();
    chk("end_frame", o_tx_data, END_W);
    slot();
    chk("end_idle", o_tx_data, 32'h0);
    chk("msg_done_pulse", 32'(o_msg_done), 32'd1);
    chk("end_busy", 32'(o_busy), 32'd0);
    tick();
    chk("msg_done_single", 32'(o_msg_done), 32'd0);
    chk("final_cnt", 32'(o_frame_cnt), 32'd3);
    chk("no_underrun", 32'(o_underrun), 32'd0);
    i_transmit = 1'b0;
    tick();

    // Pace 0 with a forced full-scale sample, then transmit released in SEND.
    i_pace     = 4'd0;
    i_transmit = 1'b1;
    tick();
    slot();
    i_cw = 1'b1;
    sample_round(13'h0000, 13'h0000, 0, 32'h9FFF_5FFE, 16'd1);
    i_cw = 1'b0;
    slot();
    chk("alt_idle", o_tx_data, 32'h0);
    sample_round(13'h0123, 13'h1ABC, 0, 32'h8247_7578, 16'd2);
    i_transmit = 1'b0;
    slot();
    chk("drop_end", o_tx_data, END_W);
    slot();
    chk("drop_msg_done", 32'(o_msg_done), 32'd1);
    tick();

    // Pace 1 underrun, late sample, then abort from PREPARE.
    i_pace     = 4'd1;
    i_transmit = 1'b1;
    tick();
    slot();
    tick();
    chk("ur_gen", 32'(o_gen_enable), 32'd1);
    slot();
    chk("ur_idle0", o_tx_data, 32'h0);
    chk("ur_clear", 32'(o_underrun), 32'd0);
    slot();
    chk("ur_idle1", o_tx_data, 32'h0);
    chk("ur_set", 32'(o_underrun), 32'd1);
    slot();
    chk("ur_idle2", o_tx_data, 32'h0);
    i_sample_i     = 13'h0000;
    i_sample_q     = 13'h0000;
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    slot();
    chk("late_sample", o_tx_data, 32'h8001_4000);
    chk("ur_sticky", 32'(o_underrun), 32'd1);
    chk("ur_cnt", 32'(o_frame_cnt), 32'd1);
    slot();
    chk("ab_send_idle", o_tx_data, 32'h0);
    i_transmit = 1'b0;
    tick();
    slot();
    chk("abort_end", o_tx_data, END_W);
    slot();
    chk("abort_idle", o_tx_data, 32'h0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    tick();

    // Pace 2, sample valid in the due slot, then reset while in SEND.
    i_pace     = 4'd2;
    i_transmit = 1'b1;
    tick();
    slot();
    chk("r4_underrun_clr", 32'(o_underrun), 32'd0);
    slot();
    slot();
    i_sample_i     = 13'h0123;
    i_sample_q     = 13'h1ABC;
    i_sample_valid = 1'b1;
    i_slot         = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    i_slot         = 1'b0;
    chk("same_clk_sample", o_tx_data, 32'h8247_7578);
    chk("same_clk_no_ur", 32'(o_underrun), 32'd0);
    chk("same_clk_cnt", 32'(o_frame_cnt), 32'd1);
    reset_n    = 1'b0;
    i_transmit = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_tx", o_tx_data, 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_cnt", 32'(o_frame_cnt), 32'd0);
    chk("mid_rst_gen", 32'(o_gen_enable), 32'd0);
    chk("mid_rst_msg_done", 32'(o_msg_done), 32'd0);
    slot();
    chk("post_rst_idle", o_tx_data, 32'h0);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    slot();
    chk("post_rst_idle2", o_tx_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
